// File: rtl/memory_game_pkg.sv
// Shared constants, playback state encoding and symbol decode for the memory game.
package memory_game_pkg;

    localparam int SYM_W   = 3;
    localparam int MAX_LEN = 25;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        DONE = 2'd3
    } playback_state_t;

    function automatic logic [7:0] sym_to_onehot(input logic [2:0] sym);
        return 8'd1 << sym;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running mod-TICK_DIV counter; tick marks the last cycle of each period.
module tick_prescaler #(
    parameter int TICK_DIV = 25000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // next count: restart on clr or at the end of a period
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/pattern_playback_ctrl.sv
// Plays a latched symbol pattern on one-hot LEDs with fixed on/off phases,
// oldest-first or newest-first, and pulses done on normal completion.
module pattern_playback_ctrl
    import memory_game_pkg::*;
#(
    parameter int SYM_W     = memory_game_pkg::SYM_W,
    parameter int MAX_LEN   = memory_game_pkg::MAX_LEN,
    parameter int PAT_W     = SYM_W * MAX_LEN,
    parameter int CNT_W     = 16,
    parameter int TICK_DIV  = 25000,
    parameter int ON_TICKS  = 4,
    parameter int OFF_TICKS = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             reverse,
    input  logic [CNT_W-1:0] len,
    input  logic [PAT_W-1:0] pattern,
    output logic             busy,
    output logic             done,
    output logic [7:0]       led,
    output logic [CNT_W-1:0] sym_idx,
    output logic             sym_valid
);

    localparam int PH_W = 8;
    localparam logic [PH_W-1:0] ON_LAST  = PH_W'(ON_TICKS - 1);
    localparam logic [PH_W-1:0] OFF_LAST = PH_W'(OFF_TICKS - 1);

    playback_state_t  state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic             rev_q, rev_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] slot_q, slot_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [PH_W-1:0]  phase_q, phase_d, phase_nx_s;
    logic [7:0]       led_q, led_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             sym_valid_q, sym_valid_d;
    logic [CNT_W-1:0] eff_len_s;
    logic [CNT_W+1:0] off_s;
    logic [SYM_W-1:0] sym_s;
    logic             tick_s;
    logic             clr_s;

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr_s),
        .tick (tick_s)
    );

    // next-state, playback bookkeeping and registered-output precompute
    always_comb begin
        state_d    = state_q;
        pat_d      = pat_q;
        rev_d      = rev_q;
        len_d      = len_q;
        slot_d     = slot_q;
        idx_d      = idx_q;
        phase_nx_s = phase_q;
        eff_len_s  = (len > CNT_W'(MAX_LEN)) ? CNT_W'(MAX_LEN) : len;

        if (abort) begin
            state_d = IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        pat_d   = pattern;
                        rev_d   = reverse;
                        len_d   = eff_len_s;
                        idx_d   = '0;
                        slot_d  = reverse ? '0 : eff_len_s - CNT_W'(1);
                        state_d = (eff_len_s == '0) ? DONE : ON;
                    end else begin
                        state_d = IDLE;
                    end
                end
                ON: begin
                    if (tick_s && (phase_q == ON_LAST)) begin
                        state_d = OFF;
                    end else if (tick_s) begin
                        phase_nx_s = phase_q + PH_W'(1);
                    end else begin
                        phase_nx_s = phase_q;
                    end
                end
                OFF: begin
                    if (tick_s && (phase_q == OFF_LAST)) begin
                        if (idx_q == len_q - CNT_W'(1)) begin
                            state_d = DONE;
                            idx_d   = '0;
                        end else begin
                            state_d = ON;
                            idx_d   = idx_q + CNT_W'(1);
                            slot_d  = rev_q ? slot_q + CNT_W'(1) : slot_q - CNT_W'(1);
                        end
                    end else if (tick_s) begin
                        phase_nx_s = phase_q + PH_W'(1);
                    end else begin
                        phase_nx_s = phase_q;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
            endcase
        end

        // both timers restart on any state change so phase lengths are exact
        clr_s   = (state_d != state_q);
        phase_d = clr_s ? '0 : phase_nx_s;

        off_s       = (CNT_W+2)'(slot_d) * (CNT_W+2)'(SYM_W);
        sym_s       = SYM_W'(pat_d >> off_s);
        led_d       = (state_d == ON) ? sym_to_onehot(sym_s) : 8'd0;
        sym_valid_d = (state_d == ON);
        busy_d      = (state_d == ON) || (state_d == OFF);
        done_d      = (state_d == DONE);
    end

    // state, latched inputs and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pat_q       <= '0;
            rev_q       <= 1'b0;
            len_q       <= '0;
            slot_q      <= '0;
            idx_q       <= '0;
            phase_q     <= '0;
            led_q       <= 8'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sym_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            rev_q       <= rev_d;
            len_q       <= len_d;
            slot_q      <= slot_d;
            idx_q       <= idx_d;
            phase_q     <= phase_d;
            led_q       <= led_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            sym_valid_q <= sym_valid_d;
        end
    end

    assign led       = led_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign sym_valid = sym_valid_q;
    assign sym_idx   = idx_q;

endmodule

// File: tb/tb_pattern_playback_ctrl.sv
// Scoreboard bench: a reference model queues the expected per-cycle outputs for
// each accepted start; a monitor pops and compares one entry per clock.
module tb_pattern_playback_ctrl;

    localparam int ONT     = 2;
    localparam int OFFT    = 1;
    localparam int MAXL    = 25;
    localparam int PAT_W   = 75;
    localparam int CNT_W   = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic             reverse;
    logic [CNT_W-1:0] len;
    logic [PAT_W-1:0] pattern;
    logic             busy;
    logic             done;
    logic [7:0]       led;
    logic [CNT_W-1:0] sym_idx;
    logic             sym_valid;

    typedef struct packed {
        logic [7:0]  led;
        logic        valid;
        logic        busy;
        logic        done;
        logic [15:0] idx;
    } obs_t;

    obs_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    bit   last_done   = 1'b0;

    pattern_playback_ctrl #(
        .TICK_DIV (1),
        .ON_TICKS (ONT),
        .OFF_TICKS(OFFT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .reverse  (reverse),
        .len      (len),
        .pattern  (pattern),
        .busy     (busy),
        .done     (done),
        .led      (led),
        .sym_idx  (sym_idx),
        .sym_valid(sym_valid)
    );

    always #5 clk = ~clk;

    function automatic void check_obs(string name, obs_t act, obs_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got led=%02h valid=%b busy=%b done=%b idx=%0d, expected led=%02h valid=%b busy=%b done=%b idx=%0d",
                     name, $time, act.led, act.valid, act.busy, act.done, act.idx,
                     exp.led, exp.valid, exp.busy, exp.done, exp.idx);
        end
    endfunction

    function automatic void check_val(string name, logic [7:0] act, logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %02h, expected %02h", name, $time, act, exp);
        end
    endfunction

    // Reference model: symbol order and phase lengths straight from the rules.
    function automatic void push_playback(input logic [15:0] l, input logic [74:0] p, input logic r);
        int         eff;
        int         k;
        logic [74:0] sh;
        obs_t       e;
        eff = (l > 16'd25) ? MAXL : int'(l);
        for (int i = 0; i < eff; i++) begin
            k       = r ? i : eff - 1 - i;
            sh      = p >> (3 * k);
            e       = '0;
            e.led   = 8'd1 << sh[2:0];
            e.valid = 1'b1;
            e.busy  = 1'b1;
            e.idx   = 16'(i);
            repeat (ONT) exp_q.push_back(e);
            e.led   = 8'd0;
            e.valid = 1'b0;
            repeat (OFFT) exp_q.push_back(e);
        end
        e      = '0;
        e.done = 1'b1;
        exp_q.push_back(e);
    endfunction

    // monitor: one expected entry per cycle, idle expected when queue is empty
    always @(negedge clk) begin
        obs_t act;
        obs_t exp;
        act = {led, sym_valid, busy, done, sym_idx};
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        else                  exp = '0;
        last_done = exp.done;
        check_obs("cycle", act, exp);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // drive a start (optionally with abort) sampled on the next edge
    task automatic pulse_start(input logic [15:0] l, input logic [74:0] p,
                               input logic r, input bit with_abort);
        bit accept;
        start   = 1'b1;
        abort   = with_abort;
        len     = l;
        pattern = p;
        reverse = r;
        @(posedge clk);
        #1;
        accept = !with_abort && (exp_q.size() == 0) && !last_done;
        start  = 1'b0;
        abort  = 1'b0;
        if (with_abort) exp_q.delete();
        else if (accept) push_playback(l, p, r);
    endtask

    task automatic do_abort();
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        exp_q.delete();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || last_done) && n < 300) begin
            tick(1);
            n++;
        end
        vectors++;
        if (n >= 300) begin
            miscompares++;
            $display("FAIL wait_idle: playback still pending after %0d cycles, expected idle", n);
            exp_q.delete();
        end
        tick(2);
    endtask

    logic [74:0] pat1;
    logic [74:0] pat_ones;
    logic [74:0] rpat;
    int          eff_r;
    int          mode;

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        reverse = 1'b0;
        len     = '0;
        pattern = '0;
        pat1    = '0;
        pat1[8:0] = {3'd5, 3'd2, 3'd7};
        pat_ones = '0;
        for (int i = 0; i < 25; i++) pat_ones[3*i +: 3] = 3'd1;

        #12;
        check_val("reset_led", led, 8'd0);
        check_val("reset_flags", {4'd0, busy, done, sym_valid, |sym_idx}, 8'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        tick(2);

        // forward, reverse, empty, clamped length
        pulse_start(16'd3, pat1, 1'b0, 1'b0);
        wait_idle();
        pulse_start(16'd3, pat1, 1'b1, 1'b0);
        wait_idle();
        pulse_start(16'd0, pat1, 1'b0, 1'b0);
        wait_idle();
        pulse_start(16'd40, pat_ones, 1'b0, 1'b0);
        wait_idle();

        // abort with simultaneous start during the second ON phase
        pulse_start(16'd3, pat1, 1'b0, 1'b0);
        tick(3);
        pulse_start(16'd3, pat1, 1'b0, 1'b1);
        tick(12);

        // re-start and pattern change mid-playback are ignored
        pulse_start(16'd3, pat1, 1'b0, 1'b0);
        tick(3);
        pulse_start(16'd7, {25{3'd6}}, 1'b1, 1'b0);
        pattern = '1;
        len     = 16'd20;
        wait_idle();

        // asynchronous reset during ON
        pulse_start(16'd3, pat1, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_val("async_rst_led", led, 8'd0);
        check_val("async_rst_busy", {7'd0, busy}, 8'd0);
        exp_q.delete();
        @(negedge clk);
        #1 rst_n = 1'b1;
        tick(3);

        // randomized playbacks with random aborts and ignored restarts
        for (int it = 0; it < 30; it++) begin
            rpat  = {$urandom, $urandom, $urandom};
            len   = 16'($urandom_range(0, 30));
            eff_r = (len > 16'd25) ? MAXL : int'(len);
            pulse_start(len, rpat, 1'($urandom_range(0, 1)), 1'b0);
            mode = $urandom_range(0, 3);
            if (mode == 0) begin
                tick($urandom_range(0, eff_r * 3 + 1));
                do_abort();
                tick(2);
            end else if (mode == 1) begin
                tick($urandom_range(0, eff_r * 3 + 1));
                rpat = {$urandom, $urandom, $urandom};
                pulse_start(16'($urandom_range(0, 30)), rpat, 1'($urandom_range(0, 1)), 1'b0);
                wait_idle();
            end else begin
                wait_idle();
            end
        end
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
